// File: rtl/sdf_twiddle_mult.sv
// -----------------------------------------------------------------------------
// sdf_twiddle_mult
//
// Twiddle-multiply stage placed between R2^2 SDF butterfly pairs. It tracks the
// sample index n within each N-point frame and derives the twiddle exponent e
// from it. e goes out as the ROM address. The sample is then multiplied by the
// registered ROM output, rounded and saturated. The stream is continuous, so
// there is no backpressure.
//
// Exponent: q = n[ADDR_WIDTH-1:ADDR_WIDTH-2], m = n mod N/4
//   e = 0 (q=0), 2m (q=1), m (q=2), 3m (q=3)
//
// Latency is 4 clock edges, counted from the edge that samples din:
//   edge 1 : tw_addr, stage-1 data/valid/sync
//   edge 2 : ROM output and stage-2 data aligned
//   edge 3 : four partial products registered
//   edge 4 : combine, round, saturate into dout
//
// Parameters
//   WIDTH      data real/imag width (signed)
//   TW_WIDTH   twiddle width, Q1.(TW_WIDTH-1), +1.0 stored as 2^(TW_WIDTH-1)-1
//   N          frame length, power of two, 4..1024
//   ADDR_WIDTH twiddle ROM address width
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   din_valid, din_sync   input qualifier, frame-start marker (index 0)
//   din_re, din_im        input sample
//   tw_addr               registered twiddle ROM address
//   tw_re, tw_im          ROM data, one-cycle registered read latency
//   dout_valid, dout_sync output qualifier and frame-start marker
//   dout_re, dout_im      rounded and saturated product
//
// Optional feature macro: TWIDDLE_TRIVIAL_BYPASS_EN
//   When it is defined, samples with e == 0 pass through unchanged. This avoids
//   the slight gain loss of the stored +1.0. Latency does not change.
// -----------------------------------------------------------------------------
module sdf_twiddle_mult #(
  parameter int WIDTH      = 16,
  parameter int TW_WIDTH   = 16,
  parameter int N          = 64,
  parameter int ADDR_WIDTH = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  din_valid,
  input  logic                  din_sync,
  input  logic [WIDTH-1:0]      din_re,
  input  logic [WIDTH-1:0]      din_im,
  output logic [ADDR_WIDTH-1:0] tw_addr,
  input  logic [TW_WIDTH-1:0]   tw_re,
  input  logic [TW_WIDTH-1:0]   tw_im,
  output logic                  dout_valid,
  output logic                  dout_sync,
  output logic [WIDTH-1:0]      dout_re,
  output logic [WIDTH-1:0]      dout_im
);

  localparam int PW    = WIDTH + TW_WIDTH;  // single product width
  localparam int SW    = PW + 1;            // sum of two products
  localparam int SHIFT = TW_WIDTH - 1;

  localparam logic [ADDR_WIDTH-1:0] M_MASK   = ADDR_WIDTH'(N / 4 - 1);
  localparam logic signed [SW-1:0]  RND_HALF = SW'(1) <<< (TW_WIDTH - 2);
  localparam logic signed [SW-1:0]  MAX_V    = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0]  MIN_V    = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Index and exponent
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] n_q;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] m;
  logic [ADDR_WIDTH-1:0] e;
  logic [1:0]            quad;

  always_comb begin
    // NOTE: every output of this block gets a value before the case, so no
    // path can leave one unassigned and infer a latch.
    idx  = din_sync ? '0 : n_q;
    quad = idx[ADDR_WIDTH-1 -: 2];
    m    = idx & M_MASK;
    e    = '0;
    case (quad)
      2'd1:    e = m << 1;
      2'd2:    e = m;
      2'd3:    e = (m << 1) + m;
      default: e = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control pipeline: counter, address, valid/sync per stage
  // ---------------------------------------------------------------------------
  logic s1_valid, s1_sync;
  logic s2_valid, s2_sync;
  logic s3_valid, s3_sync;

  // NOTE: sequential state uses non-blocking assignments only, so each stage
  // sees the previous stage's pre-edge value no matter how statements are ordered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q      <= '0;
      tw_addr  <= '0;
      s1_valid <= 1'b0;
      s1_sync  <= 1'b0;
      s2_valid <= 1'b0;
      s2_sync  <= 1'b0;
      s3_valid <= 1'b0;
      s3_sync  <= 1'b0;
    end else begin
      if (din_valid) begin
        // The counter width matches N, so N-1 -> 0 wraps by itself.
        n_q     <= idx + ADDR_WIDTH'(1);
        tw_addr <= e;
      end
      s1_valid <= din_valid;
      s1_sync  <= din_valid & din_sync;
      s2_valid <= s1_valid;
      s2_sync  <= s1_sync;
      s3_valid <= s2_valid;
      s3_sync  <= s2_sync;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: data registers, ROM alignment, partial products
  // ---------------------------------------------------------------------------
  logic signed [WIDTH-1:0] s1_re, s1_im, s2_re, s2_im;
  logic signed [PW-1:0]    p_ac, p_bd, p_ad, p_bc;

  // NOTE: datapath registers have no reset. The valid bits qualify them, and
  // leaving the reset off keeps the reset tree off the wide buses.
  always_ff @(posedge clk) begin
    s1_re <= $signed(din_re);
    s1_im <= $signed(din_im);
    s2_re <= s1_re;
    s2_im <= s1_im;
    // (a + jb)(c + jd): ROM data is valid in the cycle after edge 2.
    p_ac  <= PW'(s2_re) * PW'($signed(tw_re));
    p_bd  <= PW'(s2_im) * PW'($signed(tw_im));
    p_ad  <= PW'(s2_re) * PW'($signed(tw_im));
    p_bc  <= PW'(s2_im) * PW'($signed(tw_re));
  end

`ifdef TWIDDLE_TRIVIAL_BYPASS_EN
  logic                    s1_triv, s2_triv, s3_triv;
  logic signed [WIDTH-1:0] s3_re, s3_im;

  always_ff @(posedge clk) begin
    s1_triv <= (e == '0);
    s2_triv <= s1_triv;
    s3_triv <= s2_triv;
    s3_re   <= s2_re;
    s3_im   <= s2_im;
  end
`endif

  // ---------------------------------------------------------------------------
  // Combine, round half-up, saturate
  // ---------------------------------------------------------------------------
  logic signed [SW-1:0] sum_re, sum_im, rnd_re, rnd_im;

  always_comb begin
    sum_re = SW'(p_ac) - SW'(p_bd);
    sum_im = SW'(p_ad) + SW'(p_bc);
    rnd_re = (sum_re + RND_HALF) >>> SHIFT;
    rnd_im = (sum_im + RND_HALF) >>> SHIFT;
  end

  function automatic logic [WIDTH-1:0] saturate(input logic signed [SW-1:0] x);
    if (x > MAX_V) return MAX_V[WIDTH-1:0];
    if (x < MIN_V) return MIN_V[WIDTH-1:0];
    return x[WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid <= 1'b0;
      dout_sync  <= 1'b0;
      dout_re    <= '0;
      dout_im    <= '0;
    end else begin
      dout_valid <= s3_valid;
      dout_sync  <= s3_valid & s3_sync;
      // Data holds its last value when no valid sample arrives.
      if (s3_valid) begin
`ifdef TWIDDLE_TRIVIAL_BYPASS_EN
        if (s3_triv) begin
          dout_re <= s3_re;
          dout_im <= s3_im;
        end else begin
          dout_re <= saturate(rnd_re);
          dout_im <= saturate(rnd_im);
        end
`else
        dout_re <= saturate(rnd_re);
        dout_im <= saturate(rnd_im);
`endif
      end
    end
  end

endmodule
